// File: rtl/acc_drain_ctrl.sv
// acc_drain_ctrl: read-side master for the accumulator. A start command walks
// row_cnt rows starting at base_addr through the accumulator's registered read
// port, buffers the returned rows in a small FIFO and presents them as a
// valid/ready stream with tlast on the final row.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 command strobe, only sampled in IDLE
//   base_addr, row_cnt    first row / number of rows (0..RAM_DEPTH), latched on start
//   busy                  high from the accepted start through the done cycle
//   done                  1-cycle pulse, the cycle after the tlast beat transfers
//   acc_enb, acc_addrb    accumulator read request (data returns one cycle later)
//   acc_doutb             accumulator read data
//   m_tdata/m_tvalid/m_tready/m_tlast  output row stream
//   stall_cnt             (ACC_DRAIN_PERF_EN only) valid&!ready cycles while busy
//
// Latency: start sampled on edge N -> first read in the cycle after edge N,
// first beat valid after edge N+2.
//
// Optional feature macro: ACC_DRAIN_PERF_EN adds the stall_cnt output.
module acc_drain_ctrl #(
  parameter int OUTPUT_DATA_SIZE = 8,
  parameter int DATA_NUM         = 16,
  parameter int DOUT_WIDTH       = DATA_NUM*OUTPUT_DATA_SIZE,
  parameter int RAM_DEPTH        = 64,
  parameter int ADDR_WIDTH       = 6,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   row_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  acc_enb,
  output logic [ADDR_WIDTH-1:0] acc_addrb,
  input  logic [DOUT_WIDTH-1:0] acc_doutb,
  output logic [DOUT_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast
`ifdef ACC_DRAIN_PERF_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [ADDR_WIDTH:0]     cnt_q, issued;
  logic                    enb_last;          // tags the read currently on acc_enb
  logic                    cap_vld, cap_last; // row on acc_doutb this cycle
  logic [DOUT_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   last_mem;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count, count_nxt;
  logic                    push, pop, remaining, room;
  logic [ADDR_WIDTH:0]     addr_sum;
  logic [ADDR_WIDTH-1:0]   next_addr;

  assign m_tvalid = (count != '0);
  assign m_tdata  = mem[rd_ptr];
  assign m_tlast  = m_tvalid & last_mem[rd_ptr];
  assign push     = cap_vld;
  assign pop      = m_tvalid & m_tready;

  always_comb begin
    count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    remaining = (issued < cnt_q);
    // A read issued next cycle lands two edges later; next-cycle occupancy plus
    // the read now on acc_enb must leave a free slot for it.
    room      = ({1'b0, count_nxt} + (CNT_W+1)'(acc_enb)) < (CNT_W+1)'(FIFO_DEPTH);
    addr_sum  = {1'b0, base_q} + issued;
    next_addr = (addr_sum >= (ADDR_WIDTH+1)'(RAM_DEPTH))
              ? ADDR_WIDTH'(addr_sum - (ADDR_WIDTH+1)'(RAM_DEPTH))
              : addr_sum[ADDR_WIDTH-1:0];
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      acc_enb   <= 1'b0;
      acc_addrb <= '0;
      base_q    <= '0;
      cnt_q     <= '0;
      issued    <= '0;
      enb_last  <= 1'b0;
    end else begin
      done    <= 1'b0;
      acc_enb <= 1'b0;
      case (state)
        IDLE: if (start) begin
          base_q <= base_addr;
          cnt_q  <= row_cnt;
          busy   <= 1'b1;
          if (row_cnt == '0) begin
            issued <= '0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            // FIFO is empty in IDLE, so the first read always has a slot.
            acc_enb   <= 1'b1;
            acc_addrb <= base_addr;
            issued    <= (ADDR_WIDTH+1)'(1);
            enb_last  <= (row_cnt == (ADDR_WIDTH+1)'(1));
            state     <= RUN;
          end
        end
        RUN: begin
          if (!remaining) begin
            state <= FLUSH;
          end else if (room) begin
            acc_enb   <= 1'b1;
            acc_addrb <= next_addr;
            issued    <= issued + 1'b1;
            enb_last  <= (issued == cnt_q - 1'b1);
          end
        end
        FLUSH: begin
          // The tagged row is the last one pushed, so its transfer drains everything.
          if (pop && m_tlast) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Capture stage and output FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_vld  <= 1'b0;
      cap_last <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_mem <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      cap_vld  <= acc_enb;
      cap_last <= enb_last;
      if (push) begin
        mem[wr_ptr]      <= acc_doutb;
        last_mem[wr_ptr] <= cap_last;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

`ifdef ACC_DRAIN_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (state == IDLE && start)
      stall_cnt <= '0;
    else if (busy && m_tvalid && !m_tready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_acc_drain_ctrl.sv
// Bench for acc_drain_ctrl: accumulator read-port model, scoreboard queues
// filled when a command is driven and drained by the address/beat monitor.
module tb_acc_drain_ctrl;
  localparam int AW = 6;
  localparam int DW = 128;
  localparam int RD = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   row_cnt = '0;
  logic          busy, done, acc_enb, m_tvalid, m_tlast;
  logic          m_tready;
  logic [AW-1:0] acc_addrb;
  logic [DW-1:0] acc_doutb = '0;
  logic [DW-1:0] m_tdata;
`ifdef ACC_DRAIN_PERF_EN
  logic [15:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  acc_drain_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .row_cnt(row_cnt), .busy(busy), .done(done), .acc_enb(acc_enb),
    .acc_addrb(acc_addrb), .acc_doutb(acc_doutb), .m_tdata(m_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
`ifdef ACC_DRAIN_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // accumulator registered read port
  logic [DW-1:0] acc_mem [RD];
  always @(posedge clk) if (acc_enb) acc_doutb <= acc_mem[acc_addrb];

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  logic [AW-1:0] q_addr[$];
  logic [DW:0]   q_beat[$];

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ready pattern: 0 always, 1 one-in-three, 2 stall first stall_left valid cycles
  int rmode = 0, phase = 0, stall_left = 0;
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: m_tready = 1'b1;
        1: begin m_tready = (phase == 0); phase = (phase + 1) % 3; end
        default: begin
          if (m_tvalid && stall_left > 0) begin m_tready = 1'b0; stall_left--; end
          else m_tready = (stall_left == 0);
        end
      endcase
    end
  end

  // monitor with an independent occupancy model
  int cnt_m = 0, first_vld_cyc = -1, last_beat_cyc = -1, done_cyc = -1;
  int done_pulses = 0, vld_cycles = 0, beats = 0;
  bit enb_d1, enb_d2, pop_d1, stall_d1;
  logic [DW-1:0] tdata_d1;
  logic [DW:0]   eb;
  always @(negedge clk) begin
    if (!rst_n) begin
      cnt_m = 0; enb_d1 = 0; enb_d2 = 0; pop_d1 = 0; stall_d1 = 0;
    end else begin
      cnt_m += int'(enb_d2) - int'(pop_d1);
      chk("tvalid_model", m_tvalid, cnt_m != 0);
      if (acc_enb) begin
        chk("enb_room", (cnt_m + int'(enb_d1)) < 4, 1);
        if (q_addr.size() == 0) chk("addr_extra", 1, 0);
        else chk("addrb", acc_addrb, q_addr.pop_front());
      end
      if (stall_d1) chk("tdata_stable", m_tdata, tdata_d1);
      if (m_tvalid) begin
        vld_cycles++;
        if (first_vld_cyc < 0) first_vld_cyc = cyc;
      end
      if (m_tvalid && m_tready) begin
        beats++;
        if (q_beat.size() == 0) chk("beat_extra", 1, 0);
        else begin
          eb = q_beat.pop_front();
          chk("tdata", m_tdata, eb[DW-1:0]);
          chk("tlast", m_tlast, eb[DW]);
        end
        if (m_tlast) last_beat_cyc = cyc;
      end
      if (done) begin done_pulses++; done_cyc = cyc; end
      enb_d2 = enb_d1; enb_d1 = acc_enb;
      pop_d1 = m_tvalid && m_tready; stall_d1 = m_tvalid && !m_tready;
      tdata_d1 = m_tdata;
    end
  end

  task automatic load_exp(input int base, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      logic [AW-1:0] a;
      a = AW'((base + i) % RD);
      q_addr.push_back(a);
      q_beat.push_back({(i == cnt - 1), acc_mem[a]});
    end
    done_pulses = 0; first_vld_cyc = -1; last_beat_cyc = -1;
    vld_cycles = 0; beats = 0;
  endtask

  task automatic xfer(input int base, input int cnt, input int mode, input bit glitch);
    int s, t;
    rmode = mode;
    load_exp(base, cnt);
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(base); row_cnt = (AW+1)'(cnt); s = cyc;
    @(posedge clk); #1;
    start = 1'b0; base_addr = ~base_addr; row_cnt = 7'd5;
    if (glitch) begin
      repeat (2) @(posedge clk); #1;
      start = 1'b1; base_addr = AW'(base + 5); row_cnt = 7'd3;
      @(posedge clk); #1;
      start = 1'b0;
    end
    t = 0;
    while (done_pulses == 0 && t < 500) begin @(posedge clk); t++; end
    chk("done_timeout", done_pulses != 0, 1);
    repeat (3) @(posedge clk);
    chk("done_once", done_pulses, 1);
    chk("busy_after", busy, 0);
    chk("rows_left", q_addr.size() + q_beat.size(), 0);
    chk("beats", beats, cnt);
    if (cnt > 0) chk("done_lat", done_cyc, last_beat_cyc + 1);
    else begin
      chk("done_lat0", done_cyc, s + 1);
      chk("no_vld", vld_cycles, 0);
    end
    if (cnt > 0 && mode == 0) begin
      chk("first_lat", first_vld_cyc, s + 3);
      chk("back2back", last_beat_cyc - first_vld_cyc, cnt - 1);
    end
  endtask

  task automatic chk_reset_outs();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_enb", acc_enb, 0);
    chk("rst_addrb", acc_addrb, 0);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tdata", m_tdata, 0);
  endtask

  initial begin
    int t;
    for (int i = 0; i < RD; i++) acc_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    #12 chk_reset_outs();
    #11 rst_n = 1'b1;

    xfer(0, 8, 0, 0);     // straight run
    xfer(60, 8, 0, 0);    // address wrap 63 -> 0
    xfer(5, 16, 1, 0);    // back-pressure, one ready in three
    xfer(33, 0, 0, 0);    // empty command
    xfer(12, 8, 0, 1);    // second start during RUN ignored
    xfer(20, 64, 1, 0);   // full range

    // abort mid-transfer
    rmode = 0;
    load_exp(40, 10);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 6'd40; row_cnt = 7'd10;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (beats < 3 && t < 200) begin @(negedge clk); t++; end
    chk("abort_timeout", beats >= 3, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1 chk_reset_outs();
    q_addr.delete(); q_beat.delete();
    done_pulses = 0;
    repeat (3) @(posedge clk);
    chk("abort_no_done", done_pulses, 0);
    #3 rst_n = 1'b1;
    xfer(62, 2, 0, 0);

`ifdef ACC_DRAIN_PERF_EN
    stall_left = 5;
    xfer(10, 2, 2, 0);
    chk("stall_cnt", stall_cnt, 5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
